user_switch_conditioner: RTL and testbench

// - Front-end conditioning for the board's 4 DIP switches and 4 push switches ahead of Processor.
// - Per channel: 2-FF synchronizer into iSysClk, then a tick-based debounce filter.
// - Outputs: debounced levels plus one-cycle press/release pulses for the push switches.
// - Replaces the raw-level path so Processor sees only clean, glitch-free, synchronous controls.

---
 rtl/user_switch_if.sv | 30 +++
 rtl/user_switch_conditioner.sv | 86 ++++++++
 tb/tb_user_switch_conditioner.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/user_switch_if.sv
// Switch pins in, conditioned levels and edge pulses out.
interface user_switch_if;
  logic [3:0] iUserDipSw;
  logic [3:0] iUserPushSw;
  logic [3:0] oUserSlideSw;
  logic [3:0] oUserPushSw;
  logic [3:0] oPushPress;
  logic [3:0] oPushRelease;
  logic       oSwChange;

  modport slave (
    input  iUserDipSw,
    input  iUserPushSw,
    output oUserSlideSw,
    output oUserPushSw,
    output oPushPress,
    output oPushRelease,
    output oSwChange
  );

  modport master (
    output iUserDipSw,
    output iUserPushSw,
    input  oUserSlideSw,
    input  oUserPushSw,
    input  oPushPress,
    input  oPushRelease,
    input  oSwChange
  );
endinterface

// File: rtl/user_switch_conditioner.sv
// DIP/push switch front end: 2-FF sync, polarity fix, tick-sampled debounce
// and registered press/release/change pulses.
module user_switch_conditioner #(
  parameter int pTickDiv       = 1000,
  parameter int pStableCnt     = 8,
  parameter bit pPushActiveLow = 1'b1,
  parameter bit pDipActiveLow  = 1'b0
) (
  input  logic          iSysClk,
  input  logic          iSysRst,
  user_switch_if.slave  sw
);

  localparam int PW = (pTickDiv > 2) ? $clog2(pTickDiv) : 1;
  localparam int CW = (pStableCnt > 1) ? $clog2(pStableCnt + 1) : 1;
  localparam logic [PW-1:0] TICK_LAST  = PW'(pTickDiv - 1);
  localparam logic [CW-1:0] STABLE_CNT = CW'(pStableCnt);
  // Bit set where the pin is active low; also the inactive pin level at reset.
  localparam logic [7:0]    INV_MASK   = {{4{pPushActiveLow}}, {4{pDipActiveLow}}};

  logic [7:0]         sync1_q, sync2_q;
  logic [7:0]         s_n;
  logic [PW-1:0]      presc_q, presc_d;
  logic               tick;
  logic [7:0][CW-1:0] cnt_q, cnt_d;
  logic [7:0]         stable_q, stable_d;
  logic [7:0]         prev_q;
  logic [3:0]         press_q, release_q;
  logic               change_q;
  logic [CW-1:0]      cnt_inc;

  assign s_n  = sync2_q ^ INV_MASK;
  assign tick = (presc_q == TICK_LAST);

  always_comb begin
    presc_d  = tick ? '0 : presc_q + 1'b1;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    cnt_inc  = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_inc = cnt_q[i] + 1'b1;
      if (s_n[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_inc == STABLE_CNT) begin
          stable_d[i] = s_n[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      sync1_q   <= INV_MASK;
      sync2_q   <= INV_MASK;
      presc_q   <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      prev_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      change_q  <= 1'b0;
    end else begin
      sync1_q   <= {sw.iUserPushSw, sw.iUserDipSw};
      sync2_q   <= sync1_q;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      prev_q    <= stable_q;
      // Pulses trail the level update by one cycle.
      press_q   <= stable_q[7:4] & ~prev_q[7:4];
      release_q <= ~stable_q[7:4] & prev_q[7:4];
      change_q  <= |(stable_q ^ prev_q);
    end
  end

  assign sw.oUserSlideSw = stable_q[3:0];
  assign sw.oUserPushSw  = stable_q[7:4];
  assign sw.oPushPress   = press_q;
  assign sw.oPushRelease = release_q;
  assign sw.oSwChange    = change_q;

endmodule

// File: tb/tb_user_switch_conditioner.sv
// Bench for user_switch_conditioner: timestamp-based debounce model checked
// every cycle, plus directed press/bounce/release/reset scenarios.
module tb_user_switch_conditioner;
  localparam int D = 4;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  user_switch_if sw_if ();

  user_switch_conditioner #(
    .pTickDiv(D), .pStableCnt(N), .pPushActiveLow(1'b1), .pDipActiveLow(1'b0)
  ) dut (
    .iSysClk(clk),
    .iSysRst(rst_n),
    .sw     (sw_if.slave)
  );

  always #5 clk = ~clk;

  // Model: a bit's accepted value follows its corrected sample once that sample
  // has held unchanged across N prescaler ticks (ticks land on edges k%D==D-1).
  int         m_k;
  logic [7:0] m_d1, m_d2, m_prev_sn, m_stable, m_s1, m_s2;
  int         m_run_start [8];

  function automatic logic [7:0] corrected();
    return {~sw_if.iUserPushSw, sw_if.iUserDipSw};
  endfunction

  task automatic m_reset();
    m_k = 0; m_d1 = '0; m_d2 = '0; m_prev_sn = '0;
    m_stable = '0; m_s1 = '0; m_s2 = '0;
    for (int b = 0; b < 8; b++) m_run_start[b] = 0;
  endtask

  task automatic m_step();
    logic [7:0] sn;
    sn   = m_d2;
    m_d2 = m_d1;
    m_d1 = corrected();
    for (int b = 0; b < 8; b++)
      if (sn[b] != m_prev_sn[b]) m_run_start[b] = m_k;
    m_prev_sn = sn;
    m_s2 = m_s1;
    m_s1 = m_stable;
    if (m_k % D == D - 1)
      for (int b = 0; b < 8; b++)
        if (sn[b] != m_stable[b] && ((m_k + 1) / D - m_run_start[b] / D) == N)
          m_stable[b] = sn[b];
    m_k++;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({sw_if.oUserSlideSw, sw_if.oUserPushSw, sw_if.oPushPress,
                sw_if.oPushRelease, sw_if.oSwChange});
  endfunction

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_outs", all_outs(), 32'd0);
      end else begin
        check("m_slide",   32'(sw_if.oUserSlideSw), 32'(m_stable[3:0]));
        check("m_push",    32'(sw_if.oUserPushSw),  32'(m_stable[7:4]));
        check("m_press",   32'(sw_if.oPushPress),   32'(m_s1[7:4] & ~m_s2[7:4]));
        check("m_release", 32'(sw_if.oPushRelease), 32'(~m_s1[7:4] & m_s2[7:4]));
        check("m_change",  32'(sw_if.oSwChange),    32'(|(m_s1 ^ m_s2)));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nchg, found;
    int cd [8];
    logic [3:0] t;

    sw_if.iUserPushSw = 4'hF;
    sw_if.iUserDipSw  = 4'h0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    repeat (50) begin
      @(negedge clk);
      check("idle_after_reset", all_outs(), 32'd0);
    end

    // Clean press of push[0].
    @(negedge clk);
    sw_if.iUserPushSw[0] = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (sw_if.oUserPushSw[0]) begin lat = n; break; end
    end
    check_range("press_latency", lat, 11, 14);
    check("press_not_yet", 32'(sw_if.oPushPress), 32'd0);
    @(negedge clk);
    check("press_pulse",  32'(sw_if.oPushPress), 32'h1);
    check("press_change", 32'(sw_if.oSwChange),  32'h1);
    @(negedge clk);
    check("press_pulse_end", 32'({sw_if.oPushPress, sw_if.oSwChange}), 32'd0);

    // Bouncing push[1]: never held for 3 ticks.
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c % 5 == 0) sw_if.iUserPushSw[1] = ~sw_if.iUserPushSw[1];
      check("bounce_quiet", 32'({sw_if.oUserPushSw[1], sw_if.oPushPress[1]}), 32'd0);
    end
    sw_if.iUserPushSw[1] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("bounce_settled", 32'({sw_if.oUserPushSw[1], sw_if.oPushPress[1]}), 32'd0);
    end

    // Release push[0].
    @(negedge clk);
    sw_if.iUserPushSw[0] = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!sw_if.oUserPushSw[0]) begin lat = n; break; end
    end
    check_range("release_latency", lat, 11, 14);
    @(negedge clk);
    check("release_pulse", 32'(sw_if.oPushRelease), 32'h1);
    @(negedge clk);
    check("release_pulse_end", 32'(sw_if.oPushRelease), 32'd0);

    // DIP and push[3] together.
    @(negedge clk);
    sw_if.iUserDipSw     = 4'hA;
    sw_if.iUserPushSw[3] = 1'b0;
    nchg = 0; found = 0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      nchg += int'(sw_if.oSwChange);
      if (found == 0 && (sw_if.oUserSlideSw != 4'h0 || sw_if.oUserPushSw[3])) begin
        found = 1;
        check("simul_same_cycle", 32'({sw_if.oUserSlideSw, sw_if.oUserPushSw[3]}), 32'h15);
      end
    end
    check("simul_seen", 32'(found), 32'd1);
    check("simul_one_change", 32'(nchg), 32'd1);

    // Reset in the middle of a debounce.
    @(negedge clk);
    sw_if.iUserPushSw[2] = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_clear", all_outs(), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (sw_if.oUserPushSw[2]) begin lat = n; break; end
    end
    check("midreset_restart", 32'(lat), 32'd12);
    check("midreset_slide", 32'(sw_if.oUserSlideSw), 32'hA);
    @(negedge clk);
    check("midreset_press", 32'(sw_if.oPushPress), 32'hC);

    // Random toggling with hold times both shorter and longer than the filter.
    for (int b = 0; b < 8; b++) cd[b] = int'($urandom_range(1, 24));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1500) rst_n = 1'b0;
      if (cyc == 1503) rst_n = 1'b1;
      for (int b = 0; b < 8; b++) begin
        cd[b]--;
        if (cd[b] <= 0) begin
          cd[b] = int'($urandom_range(1, 24));
          if (b < 4) begin
            t = sw_if.iUserDipSw; t[b] = ~t[b]; sw_if.iUserDipSw = t;
          end else begin
            t = sw_if.iUserPushSw; t[b-4] = ~t[b-4]; sw_if.iUserPushSw = t;
          end
        end
      end
    end
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
